// File: rtl/key_judge.sv
// -----------------------------------------------------------------------------
// key_judge
//
// Round controller and scorer for the reaction game. Each round requests a new
// target from the random generator, waits a bounded number of game ticks for a
// debounced key press, and scores a hit or a miss. The game ends once the miss
// count reaches MISS_LIMIT and restarts from zero after `en` is dropped.
//
// Optional build macro:
//   KEY_JUDGE_PENALTY_EN - every miss also decrements `score` by 1 (floor 0).
//
// Parameters:
//   TIMEOUT_TICKS - tick pulses allowed per round before a miss (1..15)
//   MISS_LIMIT    - miss count that ends the game (1..15)
//   SCORE_MAX     - saturation value of score (fits in 7 bits)
//
// Ports:
//   clk        - system clock
//   rst_n      - synchronous active-low reset
//   en         - game enable; low returns to IDLE
//   tick       - one-cycle game tick strobe
//   key_random - target code from the generator, valid one cycle after en_random
//   key_valid  - one-cycle debounced key press strobe
//   key_code   - one-hot code of the pressed key
//   en_random  - one-cycle request for a new target
//   target     - current target shown on the LEDs (0 = none)
//   score      - saturating hit count
//   miss_cnt   - miss count
//   hit        - one-cycle pulse on a correct press
//   game_over  - high while the game is over
// -----------------------------------------------------------------------------
module key_judge #(
    parameter int TIMEOUT_TICKS = 6,
    parameter int MISS_LIMIT    = 5,
    parameter int SCORE_MAX     = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       tick,
    input  logic [3:0] key_random,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       en_random,
    output logic [3:0] target,
    output logic [6:0] score,
    output logic [3:0] miss_cnt,
    output logic       hit,
    output logic       game_over
);

    localparam logic [3:0] TICK_LAST = 4'(TIMEOUT_TICKS - 1);
    localparam logic [3:0] MISS_END  = 4'(MISS_LIMIT);
    localparam logic [6:0] SCORE_TOP = 7'(SCORE_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LOAD,
        S_WAIT,
        S_OVER
    } state_t;

    state_t     state, state_next;
    logic [3:0] tick_cnt, tick_cnt_next;
    logic [3:0] target_next;
    logic [6:0] score_next;
    logic [3:0] miss_next;
    logic       hit_next;
    logic       miss_event;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next    = state;
        tick_cnt_next = tick_cnt;
        target_next   = target;
        score_next    = score;
        miss_next     = miss_cnt;
        hit_next      = 1'b0;
        miss_event    = 1'b0;

        case (state)
            S_IDLE: begin
                target_next = 4'd0;
                if (en) state_next = S_REQ;
            end
            S_REQ: begin
                if (!en) begin
                    state_next  = S_IDLE;
                    target_next = 4'd0;
                end else begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!en) begin
                    state_next  = S_IDLE;
                    target_next = 4'd0;
                end else if (key_random == 4'd0) begin
                    // A zero code means "no target"; ask the generator again.
                    state_next = S_REQ;
                end else begin
                    target_next   = key_random;
                    tick_cnt_next = 4'd0;
                    state_next    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!en) begin
                    // Abandoned round: no score or miss update.
                    state_next  = S_IDLE;
                    target_next = 4'd0;
                end else if (key_valid) begin
                    // A press wins over a coinciding timeout tick.
                    if (key_code == target) begin
                        hit_next    = 1'b1;
                        score_next  = (score >= SCORE_TOP) ? SCORE_TOP : score + 7'd1;
                        target_next = 4'd0;
                        state_next  = S_REQ;
                    end else begin
                        miss_event = 1'b1;
                    end
                end else if (tick) begin
                    if (tick_cnt == TICK_LAST) miss_event = 1'b1;
                    else                       tick_cnt_next = tick_cnt + 4'd1;
                end
            end
            S_OVER: begin
                target_next = 4'd0;
                if (!en) begin
                    // Leaving OVER starts a fresh game.
                    state_next = S_IDLE;
                    score_next = 7'd0;
                    miss_next  = 4'd0;
                end
            end
            default: begin
                state_next  = S_IDLE;
                target_next = 4'd0;
            end
        endcase

        if (miss_event) begin
            miss_next   = miss_cnt + 4'd1;
            target_next = 4'd0;
`ifdef KEY_JUDGE_PENALTY_EN
            score_next  = (score == 7'd0) ? 7'd0 : score - 7'd1;
`else
            score_next  = score;
`endif
            state_next  = (miss_next == MISS_END) ? S_OVER : S_REQ;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            tick_cnt  <= 4'd0;
            en_random <= 1'b0;
            target    <= 4'd0;
            score     <= 7'd0;
            miss_cnt  <= 4'd0;
            hit       <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_next;
            tick_cnt  <= tick_cnt_next;
            // Request and game-over flags are registered from the next state
            // so they are high exactly while the FSM sits in REQ / OVER.
            en_random <= (state_next == S_REQ);
            target    <= target_next;
            score     <= score_next;
            miss_cnt  <= miss_next;
            hit       <= hit_next;
            game_over <= (state_next == S_OVER);
        end
    end

endmodule

// File: tb/tb_key_judge.sv
// -----------------------------------------------------------------------------
// tb_key_judge
//
// Self-checking bench for key_judge. A behavioural game model tracks the
// round phase, score, misses and target from the game rules; every cycle the
// six DUT outputs are compared with it. Directed steps cover reset, hit,
// timeout, wrong key, press on the final tick, game over, score saturation,
// zero target and (when KEY_JUDGE_PENALTY_EN is defined) the miss penalty,
// followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_key_judge;

    localparam int TO = 6;
    localparam int ML = 5;
    localparam int SM = 99;

    localparam int PH_IDLE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_LOAD = 2;
    localparam int PH_WAIT = 3;
    localparam int PH_OVER = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] key_random = 4'd0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       en_random;
    logic [3:0] target;
    logic [6:0] score;
    logic [3:0] miss_cnt;
    logic       hit;
    logic       game_over;

    int tests = 0;
    int fails = 0;

    // Game model state
    int m_phase = PH_IDLE;
    int m_score = 0;
    int m_miss  = 0;
    int m_tgt   = 0;
    int m_used  = 0;
    bit m_hit   = 1'b0;

    key_judge #(
        .TIMEOUT_TICKS(TO),
        .MISS_LIMIT   (ML),
        .SCORE_MAX    (SM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .tick      (tick),
        .key_random(key_random),
        .key_valid (key_valid),
        .key_code  (key_code),
        .en_random (en_random),
        .target    (target),
        .score     (score),
        .miss_cnt  (miss_cnt),
        .hit       (hit),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_miss();
        m_miss++;
        m_tgt = 0;
`ifdef KEY_JUDGE_PENALTY_EN
        if (m_score > 0) m_score--;
`endif
        m_phase = (m_miss == ML) ? PH_OVER : PH_REQ;
    endtask

    // One clock edge of the game rules, using the inputs held across the edge.
    task automatic model_step();
        m_hit = 1'b0;
        if (!rst_n) begin
            m_phase = PH_IDLE;
            m_score = 0;
            m_miss  = 0;
            m_tgt   = 0;
            m_used  = 0;
        end else begin
            case (m_phase)
                PH_IDLE: if (en) m_phase = PH_REQ;
                PH_REQ:  m_phase = en ? PH_LOAD : PH_IDLE;
                PH_LOAD: begin
                    if (!en)                   m_phase = PH_IDLE;
                    else if (key_random == 0)  m_phase = PH_REQ;
                    else begin
                        m_tgt   = int'(key_random);
                        m_used  = 0;
                        m_phase = PH_WAIT;
                    end
                end
                PH_WAIT: begin
                    if (!en) begin
                        m_phase = PH_IDLE;
                        m_tgt   = 0;
                    end else if (key_valid) begin
                        if (int'(key_code) == m_tgt) begin
                            m_hit   = 1'b1;
                            m_score = (m_score + 1 > SM) ? SM : m_score + 1;
                            m_tgt   = 0;
                            m_phase = PH_REQ;
                        end else begin
                            model_miss();
                        end
                    end else if (tick) begin
                        m_used++;
                        if (m_used == TO) model_miss();
                    end
                end
                PH_OVER: begin
                    if (!en) begin
                        m_phase = PH_IDLE;
                        m_score = 0;
                        m_miss  = 0;
                    end
                end
                default: m_phase = PH_IDLE;
            endcase
        end
    endtask

    task automatic compare_all();
        check("en_random", 8'(en_random), 8'(m_phase == PH_REQ));
        check("target",    8'(target),    8'(m_tgt));
        check("score",     8'(score),     8'(m_score));
        check("miss_cnt",  8'(miss_cnt),  8'(m_miss));
        check("hit",       8'(hit),       8'(m_hit));
        check("game_over", 8'(game_over), 8'(m_phase == PH_OVER));
    endtask

    // Drive inputs at the falling edge, advance the model on the rising edge,
    // compare shortly after. The generator answers a request with kr.
    task automatic step(input logic e, input logic t, input logic kv,
                        input logic [3:0] kc, input logic [3:0] kr);
        @(negedge clk);
        en        = e;
        tick      = t;
        key_valid = kv;
        key_code  = kc;
        if (en_random) key_random = kr;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic go_to_wait(input logic [3:0] kr);
        for (int i = 0; i < 8 && m_phase != PH_WAIT; i++)
            step(1'b1, 1'b0, 1'b0, 4'd0, kr);
        check("reach_wait", 8'(target != 4'd0), 8'd1);
    endtask

    function automatic logic [3:0] onehot();
        logic [3:0] v;
        v = 4'b0001 << $urandom_range(3);
        return v;
    endfunction

    initial begin
        // Reset held for two cycles with en high
        rst_n = 1'b0;
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        check("rst_score", 8'(score), 8'd0);
        check("rst_en_random", 8'(en_random), 8'd0);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'b0100);
        check("first_req", 8'(en_random), 8'd1);

        // Hit
        go_to_wait(4'b0100);
        check("hit_target_shown", 8'(target), 8'd4);
        step(1'b1, 1'b0, 1'b1, 4'b0100, 4'b0010);
        check("hit_pulse", 8'(hit), 8'd1);
        check("hit_score", 8'(score), 8'd1);
        check("hit_target_clr", 8'(target), 8'd0);
        check("hit_next_req", 8'(en_random), 8'd1);
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'b0010);
        check("hit_one_cycle", 8'(hit), 8'd0);

        // Timeout after TO ticks
        go_to_wait(4'b0010);
        for (int i = 0; i < TO - 1; i++) step(1'b1, 1'b1, 1'b0, 4'd0, 4'b0010);
        check("timeout_early", 8'(miss_cnt), 8'd0);
        step(1'b1, 1'b1, 1'b0, 4'd0, 4'b0010);
        check("timeout_miss", 8'(miss_cnt), 8'd1);
        check("timeout_req", 8'(en_random), 8'd1);

        // Wrong key
        go_to_wait(4'b0010);
        step(1'b1, 1'b0, 1'b1, 4'b0001, 4'b0010);
        check("wrong_key_miss", 8'(miss_cnt), 8'd2);

        // Correct key on the final tick is a hit
        go_to_wait(4'b0010);
        for (int i = 0; i < TO - 1; i++) step(1'b1, 1'b1, 1'b0, 4'd0, 4'b0010);
        step(1'b1, 1'b1, 1'b1, 4'b0010, 4'b1000);
        check("final_tick_hit", 8'(hit), 8'd1);
        check("final_tick_no_miss", 8'(miss_cnt), 8'd2);

        // Three more wrong keys end the game
        for (int r = 0; r < 3; r++) begin
            go_to_wait(4'b1000);
            step(1'b1, 1'b0, 1'b1, 4'b0001, 4'b1000);
        end
        check("over_flag", 8'(game_over), 8'd1);
        check("over_misses", 8'(miss_cnt), 8'(ML));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 4'b0001, 4'b1000);
        check("over_no_req", 8'(en_random), 8'd0);

        // Dropping en clears the game
        step(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        check("restart_score", 8'(score), 8'd0);
        check("restart_miss", 8'(miss_cnt), 8'd0);
        check("restart_over", 8'(game_over), 8'd0);

`ifdef KEY_JUDGE_PENALTY_EN
        // Miss at score 0 stays 0; miss at score 3 gives 2
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'b0001);
        go_to_wait(4'b0001);
        step(1'b1, 1'b0, 1'b1, 4'b0010, 4'b0001);
        check("penalty_floor", 8'(score), 8'd0);
        for (int r = 0; r < 3; r++) begin
            go_to_wait(4'b0001);
            step(1'b1, 1'b0, 1'b1, 4'b0001, 4'b0001);
        end
        go_to_wait(4'b0001);
        step(1'b1, 1'b0, 1'b1, 4'b0100, 4'b0001);
        check("penalty_dec", 8'(score), 8'd2);
`endif

        // Saturation: enough hits to pass SCORE_MAX
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'b1000);
        for (int r = 0; r < SM; r++) begin
            go_to_wait(4'b1000);
            step(1'b1, 1'b0, 1'b1, 4'b1000, 4'b1000);
        end
        check("sat_reach", 8'(score), 8'(SM));
        go_to_wait(4'b1000);
        step(1'b1, 1'b0, 1'b1, 4'b1000, 4'd0);
        check("sat_hit", 8'(hit), 8'd1);
        check("sat_hold", 8'(score), 8'(SM));

        // Zero target: re-request without touching target
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        check("zero_rereq", 8'(en_random), 8'd1);
        check("zero_no_target", 8'(target), 8'd0);
        go_to_wait(4'b0100);

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            logic       e, t, kv;
            logic [3:0] kc, kr;
            rst_n = ($urandom_range(199) != 0);
            e  = ($urandom_range(99) >= 5);
            t  = ($urandom_range(2) == 0);
            kv = ($urandom_range(3) == 0);
            kc = ($urandom_range(1) == 1 && m_tgt != 0) ? 4'(m_tgt) : onehot();
            kr = ($urandom_range(4) == 0) ? 4'd0 : onehot();
            step(e, t, kv, kc, kr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
